// File: rtl/shim_trigger_pkg.sv
// Shared opcodes, CANCEL word, FSM state type and opcode check
// for the trigger command sequencer.
package shim_trigger_pkg;

    localparam logic [2:0] CMD_SYNC_CH         = 3'd1;
    localparam logic [2:0] CMD_SET_LOCKOUT     = 3'd2;
    localparam logic [2:0] CMD_EXPECT_EXT_TRIG = 3'd3;
    localparam logic [2:0] CMD_DELAY           = 3'd4;
    localparam logic [2:0] CMD_FORCE_TRIG      = 3'd5;
    localparam logic [2:0] CMD_CANCEL          = 3'd7;

    localparam logic [31:0] CANCEL_WORD = {CMD_CANCEL, 29'd0};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PUSH,
        S_ABORT,
        S_ERROR
    } seq_state_t;

    function automatic logic op_valid(input logic [2:0] op);
        logic ok;
        unique case (op)
            CMD_SYNC_CH, CMD_SET_LOCKOUT, CMD_EXPECT_EXT_TRIG,
            CMD_DELAY, CMD_FORCE_TRIG, CMD_CANCEL: ok = 1'b1;
            default:                               ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/shim_trigger_cmd_sequencer_prog_ram.sv
// Program store: one write port, one registered read port.
// No reset on the array or read register so it maps onto block RAM.
module shim_seq_prog_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];

    // Write port and one-cycle registered read
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/shim_trigger_cmd_sequencer.sv
// Replays a stored program of trigger commands into the command FIFO,
// with N-pass looping, abort with CANCEL injection and opcode checking.
module shim_trigger_cmd_sequencer
    import shim_trigger_pkg::*;
#(
    parameter int PROG_DEPTH = 256,
    parameter int LOOP_WIDTH = 16,
    localparam int AW = $clog2(PROG_DEPTH)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  prog_wr_en,
    input  logic [AW-1:0]         prog_wr_addr,
    input  logic [31:0]           prog_wr_data,
    input  logic [AW:0]           prog_len,
    input  logic [LOOP_WIDTH-1:0] loop_count,
    input  logic                  start,
    input  logic                  abort,
    output logic                  cmd_wr_en,
    output logic [31:0]           cmd_word,
    input  logic                  cmd_buf_full,
    output logic                  busy,
    output logic                  done,
    output logic [AW-1:0]         cur_addr,
    output logic [LOOP_WIDTH-1:0] passes_left,
    output logic                  seq_error,
    output logic                  prog_wr_conflict
);

    localparam logic [AW:0] DEPTH_LEN = (AW+1)'(PROG_DEPTH);

    seq_state_t            state, state_nxt;
    logic [AW:0]           addr, addr_nxt;
    logic [AW:0]           len, len_nxt;
    logic [LOOP_WIDTH-1:0] passes, passes_nxt;
    logic                  done_nxt;
    logic                  err_set;
    logic                  rd_en;
    logic [31:0]           rd_data;
    logic                  len_ok;
    logic                  last_word;

    assign busy = (state == S_FETCH) || (state == S_PUSH)
               || (state == S_ABORT);
    assign len_ok = (prog_len != '0) && (prog_len <= DEPTH_LEN);
    assign last_word = (addr == len - (AW+1)'(1));
    assign cur_addr = addr[AW-1:0];
    assign passes_left = passes;

    shim_seq_prog_ram #(
        .DEPTH (PROG_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (prog_wr_en && !busy),
        .wr_addr (prog_wr_addr),
        .wr_data (prog_wr_data),
        .rd_en   (rd_en),
        .rd_addr (addr[AW-1:0]),
        .rd_data (rd_data)
    );

    // State, counters and sticky flags
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state            <= S_IDLE;
            addr             <= '0;
            len              <= '0;
            passes           <= '0;
            done             <= 1'b0;
            seq_error        <= 1'b0;
            prog_wr_conflict <= 1'b0;
        end else begin
            state            <= state_nxt;
            addr             <= addr_nxt;
            len              <= len_nxt;
            passes           <= passes_nxt;
            done             <= done_nxt;
            seq_error        <= seq_error | err_set;
            prog_wr_conflict <= prog_wr_conflict | (prog_wr_en && busy);
        end
    end

    // Next state, FIFO handshake and word selection
    always_comb begin
        state_nxt  = state;
        addr_nxt   = addr;
        len_nxt    = len;
        passes_nxt = passes;
        done_nxt   = 1'b0;
        err_set    = 1'b0;
        rd_en      = 1'b0;
        cmd_wr_en  = 1'b0;
        cmd_word   = '0;
        unique case (state)
            S_IDLE, S_ERROR: begin
                if (start) begin
                    if (len_ok) begin
                        len_nxt    = prog_len;
                        passes_nxt = loop_count;
                        addr_nxt   = '0;
                        state_nxt  = S_FETCH;
                    end else begin
                        err_set   = 1'b1;
                        state_nxt = S_ERROR;
                    end
                end
            end
            S_FETCH: begin
                rd_en = 1'b1;
                state_nxt = abort ? S_ABORT : S_PUSH;
            end
            S_PUSH: begin
                cmd_word = rd_data;
                if (abort) begin
                    state_nxt = S_ABORT;
                end else if (!op_valid(rd_data[31:29])) begin
                    err_set   = 1'b1;
                    state_nxt = S_ERROR;
                end else if (!cmd_buf_full) begin
                    cmd_wr_en = 1'b1;
                    if (!last_word) begin
                        addr_nxt  = addr + (AW+1)'(1);
                        state_nxt = S_FETCH;
                    end else if (passes != '0) begin
                        passes_nxt = passes - LOOP_WIDTH'(1);
                        addr_nxt   = '0;
                        state_nxt  = S_FETCH;
                    end else begin
                        done_nxt  = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_ABORT: begin
                cmd_word = CANCEL_WORD;
                if (!cmd_buf_full) begin
                    cmd_wr_en = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_shim_trigger_cmd_sequencer.sv
// Randomized bench for the command sequencer: expected FIFO
// traffic is built from the program contents, pass count and rules.
module tb_shim_trigger_cmd_sequencer;

    localparam int PD = 16;
    localparam int LW = 4;
    localparam int AW = 4;
    localparam logic [31:0] CANCEL = 32'hE000_0000;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          prog_wr_en = 1'b0;
    logic [AW-1:0] prog_wr_addr = '0;
    logic [31:0]   prog_wr_data = '0;
    logic [AW:0]   prog_len = '0;
    logic [LW-1:0] loop_count = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          cmd_buf_full = 1'b0;
    logic          cmd_wr_en;
    logic [31:0]   cmd_word;
    logic          busy;
    logic          done;
    logic [AW-1:0] cur_addr;
    logic [LW-1:0] passes_left;
    logic          seq_error;
    logic          prog_wr_conflict;

    always #5 clk = ~clk;

    shim_trigger_cmd_sequencer #(
        .PROG_DEPTH (PD),
        .LOOP_WIDTH (LW)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .prog_wr_en       (prog_wr_en),
        .prog_wr_addr     (prog_wr_addr),
        .prog_wr_data     (prog_wr_data),
        .prog_len         (prog_len),
        .loop_count       (loop_count),
        .start            (start),
        .abort            (abort),
        .cmd_wr_en        (cmd_wr_en),
        .cmd_word         (cmd_word),
        .cmd_buf_full     (cmd_buf_full),
        .busy             (busy),
        .done             (done),
        .cur_addr         (cur_addr),
        .passes_left      (passes_left),
        .seq_error        (seq_error),
        .prog_wr_conflict (prog_wr_conflict)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int t0 = 0;

    logic [31:0] ref_mem [PD];
    bit          ref_err = 0;
    bit          ref_conf = 0;

    logic [31:0] got_w[$];
    int          got_a[$];
    int          got_p[$];
    int          got_c[$];
    int          done_c[$];

    // Cycle counter used to time-stamp observed writes
    always @(posedge clk) cyc <= cyc + 1;

    // Record every FIFO write and done pulse mid-cycle
    always @(negedge clk) begin
        if (cmd_wr_en) begin
            got_w.push_back(cmd_word);
            got_a.push_back(int'(cur_addr));
            got_p.push_back(int'(passes_left));
            got_c.push_back(cyc);
        end
        if (done) done_c.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit op_ok(input logic [2:0] op);
        return (op >= 3'd1 && op <= 3'd5) || op == 3'd7;
    endfunction

    function automatic logic [31:0] rnd_word(input bit allow_bad);
        logic [2:0] op;
        int r;
        r = $urandom_range(5);
        op = (r == 5) ? 3'd7 : 3'(r + 1);
        if (allow_bad && $urandom_range(19) == 0)
            op = ($urandom_range(1) == 0) ? 3'd0 : 3'd6;
        return {op, 29'($urandom)};
    endfunction

    task automatic clear_obs();
        got_w.delete();
        got_a.delete();
        got_p.delete();
        got_c.delete();
        done_c.delete();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cmd_buf_full = 1'b0;
        prog_wr_en = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        ref_err = 0;
        ref_conf = 0;
    endtask

    task automatic load(input int a, input logic [31:0] d);
        prog_wr_en = 1'b1;
        prog_wr_addr = AW'(a);
        prog_wr_data = d;
        tick();
        prog_wr_en = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic run(input int len, input int loops, input int full_pct,
                       input int hold_lo, input int hold_hi,
                       input int abort_at, input int conf_at,
                       input bit hold_chk);
        logic [31:0] ew[$];
        int ea[$];
        int ep[$];
        bit bad, len_ok, aborted, fin;
        bad = 0;
        aborted = 0;
        fin = 0;
        len_ok = (len >= 1) && (len <= PD);
        if (len_ok)
            for (int p = 0; p <= loops; p++)
                for (int i = 0; i < len; i++)
                    if (!bad) begin
                        if (!op_ok(ref_mem[i][31:29])) bad = 1;
                        else begin
                            ew.push_back(ref_mem[i]);
                            ea.push_back(i);
                            ep.push_back(loops - p);
                        end
                    end
        if (!len_ok || bad) ref_err = 1;
        clear_obs();
        prog_len = (AW+1)'(len);
        loop_count = LW'(loops);
        start = 1'b1;
        abort = (abort_at == -2);
        t0 = cyc;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int k = 0; k < 4000 && !fin; k++) begin
            cmd_buf_full = (k >= hold_lo && k <= hold_hi)
                        || ($urandom_range(99) < full_pct);
            if (k == abort_at && busy) begin
                abort = 1'b1;
                aborted = 1;
            end
            if (k == conf_at && busy) begin
                prog_wr_en = 1'b1;
                prog_wr_addr = '0;
                prog_wr_data = ~ref_mem[0];
                ref_conf = 1;
            end
            if (hold_chk && k >= 3 && k <= hold_hi) begin
                @(negedge clk);
                check("hold_word", cmd_word, ref_mem[1]);
                check("hold_wr_en", 32'(cmd_wr_en), 0);
            end
            tick();
            abort = 1'b0;
            prog_wr_en = 1'b0;
            if (!busy) fin = 1;
        end
        cmd_buf_full = 1'b0;
        tick();
        check("finished", 32'(fin), 1);
        if (aborted) begin
            check("abort_count",
                  32'(got_w.size() >= 1 && got_w.size() <= ew.size() + 1), 1);
            for (int i = 0; i < got_w.size() - 1 && i < ew.size(); i++)
                check("abort_prefix", got_w[i], ew[i]);
            if (got_w.size() > 0) check("cancel_word", got_w[$], CANCEL);
            check("abort_no_done", done_c.size(), 0);
        end else begin
            check("n_writes", got_w.size(), ew.size());
            for (int i = 0; i < got_w.size() && i < ew.size(); i++) begin
                check("word", got_w[i], ew[i]);
                check("addr", got_a[i], ea[i]);
                check("passes", got_p[i], ep[i]);
            end
            check("done_n", done_c.size(), (len_ok && !bad) ? 1 : 0);
        end
        check("seq_error", 32'(seq_error), 32'(ref_err));
        check("conflict", 32'(prog_wr_conflict), 32'(ref_conf));
        check("busy_end", 32'(busy), 0);
    endtask

    initial begin : main
        int len;
        int loops;
        int ab;
        int n0;
        bit ok;

        do_reset();
        check("rst_wr_en", 32'(cmd_wr_en), 0);
        check("rst_word", cmd_word, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_addr", 32'(cur_addr), 0);
        check("rst_passes", 32'(passes_left), 0);
        check("rst_err", 32'(seq_error), 0);
        check("rst_conf", 32'(prog_wr_conflict), 0);

        load(0, {3'd4, 29'd10});
        load(1, {3'd5, 29'd0});
        load(2, {3'd3, 29'd2});
        run(3, 0, 0, -1, -1, -1, -1, 0);
        for (int i = 0; i < 3 && i < got_c.size(); i++)
            check("write_time", got_c[i] - t0, 2 + 2 * i);
        if (done_c.size() > 0) check("done_time", done_c[0] - t0, 7);

        run(3, 2, 0, -1, -1, -1, -1, 0);
        run(3, 0, 0, 2, 6, -1, -1, 1);
        run(3, 0, 0, -1, -1, -2, -1, 0);

        run(1, 0, 0, 0, 5, 1, -1, 0);
        check("abort_full_n", got_w.size(), 1);

        clear_obs();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        check("idle_abort_n", got_w.size(), 0);

        load(1, {3'd6, 29'd5});
        run(3, 0, 0, -1, -1, -1, -1, 0);
        run(1, 0, 0, -1, -1, -1, -1, 0);

        do_reset();
        run(0, 0, 0, -1, -1, -1, -1, 0);
        run(PD + 1, 0, 0, -1, -1, -1, -1, 0);
        do_reset();

        for (int i = 0; i < PD; i++) load(i, rnd_word(0));
        run(4, 1, 0, -1, -1, -1, 2, 0);
        run(1, 0, 0, -1, -1, -1, -1, 0);
        run(PD, 1, 20, -1, -1, -1, -1, 0);
        run(1, (1 << LW) - 1, 0, -1, -1, -1, -1, 0);

        prog_len = 5'd4;
        loop_count = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        ref_err = 0;
        ref_conf = 0;
        n0 = got_w.size();
        tick();
        tick();
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_nocancel", got_w.size(), n0);

        for (int it = 0; it < 30; it++) begin
            len = $urandom_range(1, PD);
            loops = $urandom_range(0, 3);
            ab = -1;
            ok = 1;
            if ($urandom_range(3) == 0)
                for (int i = 0; i < PD; i++) load(i, rnd_word(1));
            for (int i = 0; i < len; i++)
                if (!op_ok(ref_mem[i][31:29])) ok = 0;
            if (ok && $urandom_range(1) == 1)
                ab = $urandom_range(0, 3 * len);
            run(len, loops, $urandom_range(0, 40), -1, -1, ab, -1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
